sc_timer_backg: RTL and testbench

SC_TIMER_BACKG -- requirements
Module: sc_timer_backg

---
 rtl/sc_timer_backg_if.sv | 28 ++
 rtl/sc_timer_backg.sv | 184 ++++++++++++++++++
 tb/tb_sc_timer_backg.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sc_timer_backg_if.sv
// sc_timer_backg_if -- timer bus between the background shift controller
// (master: drives clear/upcount) and the timer responder (slave: returns
// the T0 pulse plus the count and level observation outputs).
interface sc_timer_backg_if #(
  parameter int COUNT_WIDTH = 24
);
  logic                   SC_TIMER_BACKG_clear_InLow;
  logic                   SC_TIMER_BACKG_upcount_InLow;
  logic                   SC_TIMER_BACKG_T0_OutLow;
  logic [COUNT_WIDTH-1:0] SC_TIMER_BACKG_count_Out;
  logic [3:0]             SC_TIMER_BACKG_level_Out;

  modport master (
    output SC_TIMER_BACKG_clear_InLow,
    output SC_TIMER_BACKG_upcount_InLow,
    input  SC_TIMER_BACKG_T0_OutLow,
    input  SC_TIMER_BACKG_count_Out,
    input  SC_TIMER_BACKG_level_Out
  );

  modport slave (
    input  SC_TIMER_BACKG_clear_InLow,
    input  SC_TIMER_BACKG_upcount_InLow,
    output SC_TIMER_BACKG_T0_OutLow,
    output SC_TIMER_BACKG_count_Out,
    output SC_TIMER_BACKG_level_Out
  );
endinterface

// File: rtl/sc_timer_backg.sv
// sc_timer_backg -- timeout responder for the background shift controller.
// Counts enabled cycles (upcount low) up to period-1, then wraps to 0 and
// emits a one-cycle active-low T0 pulse. Clear (active low) restarts it.
// Optional feature macro: SC_TIMER_BACKG_SPEEDUP_EN -- every LEVEL_PULSES-th
// wrap shortens the period by PERIOD_STEP (floored at PERIOD_MIN) and bumps
// the 4-bit speed level. Without the macro the period is fixed at
// PERIOD_INIT and the level output is constant 0.
module sc_timer_backg #(
  parameter int COUNT_WIDTH  = 24,
  parameter int PERIOD_INIT  = 12500000,
  parameter int PERIOD_MIN   = 2500000,
  parameter int PERIOD_STEP  = 1250000,
  parameter int LEVEL_PULSES = 8
) (
  input  logic              SC_TIMER_BACKG_CLOCK_50,
  input  logic              SC_TIMER_BACKG_RESET_InHigh,
  sc_timer_backg_if.slave   tmr_bus
);

  // Reject parameter sets the counter cannot honour.
  if ((PERIOD_INIT < PERIOD_MIN) || (PERIOD_MIN < 2) || (LEVEL_PULSES < 1) ||
      (PERIOD_STEP < 0) || (longint'(PERIOD_INIT) >= (longint'(1) << COUNT_WIDTH))) begin : g_param_check
    $fatal(1, "sc_timer_backg: illegal parameter set");
  end

  localparam logic [COUNT_WIDTH-1:0] P_INIT   = COUNT_WIDTH'(PERIOD_INIT);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] count_next_s;
  logic                   t0_r;
  logic                   t0_next_s;
  logic                   wrap_s;
  logic [COUNT_WIDTH-1:0] period_s;

  logic clear_s;
  logic enable_s;
  assign clear_s  = ~tmr_bus.SC_TIMER_BACKG_clear_InLow;
  assign enable_s = ~tmr_bus.SC_TIMER_BACKG_upcount_InLow;

  // Next-state, next-count and next-T0 decode; clear overrides any wrap.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    t0_next_s    = 1'b1;
    wrap_s       = 1'b0;
    if (clear_s) begin
      state_next_s = ST_IDLE;
      count_next_s = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Leaving IDLE takes one edge; counting starts in RUN.
          state_next_s = ST_RUN;
          count_next_s = CNT_ZERO;
        end
        ST_RUN: begin
          if (enable_s) begin
            if (count_r == (period_s - CNT_ONE)) begin
              count_next_s = CNT_ZERO;
              wrap_s       = 1'b1;
              state_next_s = ST_FIRE;
              t0_next_s    = 1'b0;
            end else begin
              count_next_s = count_r + CNT_ONE;
            end
          end else begin
            // Held at period-1 the wrap stays pending until re-enabled.
            count_next_s = count_r;
          end
        end
        ST_FIRE: begin
          // Keep counting through the pulse cycle so no cycle is lost.
          state_next_s = ST_RUN;
          if (enable_s) begin
            count_next_s = count_r + CNT_ONE;
          end else begin
            count_next_s = count_r;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          count_next_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count and registered T0 pulse; reset aborts any pending pulse.
  always_ff @(posedge SC_TIMER_BACKG_CLOCK_50) begin
    if (SC_TIMER_BACKG_RESET_InHigh) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      t0_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      t0_r    <= t0_next_s;
    end
  end

`ifdef SC_TIMER_BACKG_SPEEDUP_EN
  localparam int                     PCW    = (LEVEL_PULSES > 1) ? $clog2(LEVEL_PULSES) : 1;
  localparam logic [PCW-1:0]         P_LAST = PCW'(LEVEL_PULSES - 1);
  localparam logic [PCW-1:0]         P_ZERO = PCW'(0);
  localparam logic [PCW-1:0]         P_ONE  = PCW'(1);
  localparam logic [COUNT_WIDTH-1:0] P_MIN  = COUNT_WIDTH'(PERIOD_MIN);
  localparam logic [COUNT_WIDTH-1:0] P_STEP = COUNT_WIDTH'(PERIOD_STEP);

  logic [COUNT_WIDTH-1:0] period_r;
  logic [COUNT_WIDTH-1:0] period_next_s;
  logic [3:0]             level_r;
  logic [3:0]             level_next_s;
  logic [PCW-1:0]         pulse_r;
  logic [PCW-1:0]         pulse_next_s;

  // Speed-step decode: count wraps, step the period on every LEVEL_PULSES-th.
  always_comb begin
    period_next_s = period_r;
    level_next_s  = level_r;
    pulse_next_s  = pulse_r;
    if (clear_s) begin
      period_next_s = P_INIT;
      level_next_s  = 4'd0;
      pulse_next_s  = P_ZERO;
    end else if (wrap_s) begin
      if (pulse_r == P_LAST) begin
        pulse_next_s = P_ZERO;
        if (period_r != P_MIN) begin
          // Compare the headroom first so the subtraction never underflows.
          if ((period_r - P_MIN) > P_STEP) begin
            period_next_s = period_r - P_STEP;
          end else begin
            period_next_s = P_MIN;
          end
          if (level_r != 4'd15) begin
            level_next_s = level_r + 4'd1;
          end else begin
            level_next_s = level_r;
          end
        end else begin
          period_next_s = period_r;
        end
      end else begin
        pulse_next_s = pulse_r + P_ONE;
      end
    end else begin
      pulse_next_s = pulse_r;
    end
  end

  // Period, level and wrap-counter registers.
  always_ff @(posedge SC_TIMER_BACKG_CLOCK_50) begin
    if (SC_TIMER_BACKG_RESET_InHigh) begin
      period_r <= P_INIT;
      level_r  <= 4'd0;
      pulse_r  <= P_ZERO;
    end else begin
      period_r <= period_next_s;
      level_r  <= level_next_s;
      pulse_r  <= pulse_next_s;
    end
  end

  assign period_s                         = period_r;
  assign tmr_bus.SC_TIMER_BACKG_level_Out = level_r;
`else
  assign period_s                         = P_INIT;
  assign tmr_bus.SC_TIMER_BACKG_level_Out = 4'd0;
`endif

  assign tmr_bus.SC_TIMER_BACKG_T0_OutLow = t0_r;
  assign tmr_bus.SC_TIMER_BACKG_count_Out = count_r;

endmodule

// File: tb/tb_sc_timer_backg.sv
// tb_sc_timer_backg -- directed, table-driven bench for sc_timer_backg with
// PERIOD_INIT=5, PERIOD_MIN=2, PERIOD_STEP=1, LEVEL_PULSES=2. Each table row
// gives the inputs for one cycle and the outputs expected after that edge.
module tb_sc_timer_backg;

  localparam int CW = 8;

  logic clk;
  logic rst;

  sc_timer_backg_if #(.COUNT_WIDTH(CW)) tmr_bus ();

  sc_timer_backg #(
    .COUNT_WIDTH (CW),
    .PERIOD_INIT (5),
    .PERIOD_MIN  (2),
    .PERIOD_STEP (1),
    .LEVEL_PULSES(2)
  ) dut (
    .SC_TIMER_BACKG_CLOCK_50    (clk),
    .SC_TIMER_BACKG_RESET_InHigh(rst),
    .tmr_bus                    (tmr_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          clr;
    logic          up;
    logic          t0;
    logic [CW-1:0] cnt;
    logic [3:0]    lvl;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic c, input logic u,
                     input logic t0, input int cnt, input int lvl);
    vec_t v;
    v.rst = r; v.clr = c; v.up = u; v.t0 = t0;
    v.cnt = CW'(cnt); v.lvl = 4'(lvl);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst;
    tmr_bus.SC_TIMER_BACKG_clear_InLow   = v.clr;
    tmr_bus.SC_TIMER_BACKG_upcount_InLow = v.up;
    @(posedge clk);
    #1;
    chk("t0",    idx, int'(tmr_bus.SC_TIMER_BACKG_T0_OutLow), int'(v.t0));
    chk("count", idx, int'(tmr_bus.SC_TIMER_BACKG_count_Out), int'(v.cnt));
    chk("level", idx, int'(tmr_bus.SC_TIMER_BACKG_level_Out), int'(v.lvl));
  endtask

  initial begin
    int per[9];
    int lv[9];
    rst = 1'b1;
    tmr_bus.SC_TIMER_BACKG_clear_InLow   = 1'b1;
    tmr_bus.SC_TIMER_BACKG_upcount_InLow = 1'b0;

    // Reset for two edges, then IDLE -> RUN on the first clear-high edge.
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0);

`ifdef SC_TIMER_BACKG_SPEEDUP_EN
    // Speed-up: periods 5,5,4,4,3,3,2,2,2 with level 0,0,1,1,2,2,3,3,3.
    per = '{5, 5, 4, 4, 3, 3, 2, 2, 2};
    lv  = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
    for (int p = 0; p < 9; p++) begin
      for (int c = 0; c < per[p]; c++) begin
        if (!(p == 0 && c == 0)) add(0, 1, 0, (c == 0) ? 1'b0 : 1'b1, c, lv[p]);
      end
    end
    add(0, 1, 0, 0, 0, 3);
`else
    per = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
    lv  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    // Continuous enable: pulses at cycles 5, 10, 15.
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c < per[k]; c++) add(0, 1, 0, 1, c, lv[k]);
      add(0, 1, 0, 0, 0, 0);
    end
    // Hold three cycles at count 2: pulse slips by exactly three cycles.
    add(0, 1, 0, 1, 1, 0);
    add(0, 1, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 2, 0);
    add(0, 1, 0, 1, 3, 0);
    add(0, 1, 0, 1, 4, 0);
    add(0, 1, 0, 0, 0, 0);
    // Hold at period-1: the wrap stays pending.
    for (int c = 1; c < 5; c++) add(0, 1, 0, 1, c, 0);
    add(0, 1, 1, 1, 4, 0);
    add(0, 1, 1, 1, 4, 0);
    add(0, 1, 0, 0, 0, 0);
    // Clear on the count==4 cycle wins over the wrap.
    for (int c = 1; c < 5; c++) add(0, 1, 0, 1, c, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    for (int c = 1; c < 5; c++) add(0, 1, 0, 1, c, 0);
    add(0, 1, 0, 0, 0, 0);
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    // The table ends in the FIRE cycle: reset there must abort everything.
    begin
      vec_t v;
      int   base;
      base = tbl.size();
      v = '{rst: 1'b1, clr: 1'b1, up: 1'b0, t0: 1'b1, cnt: CW'(0), lvl: 4'd0};
      apply(v, base);
      // Back in IDLE: one edge to RUN without counting.
      v.rst = 1'b0;
      apply(v, base + 1);
      // Period is back to 5 and level to 0.
      for (int c = 1; c < 5; c++) begin
        v.cnt = CW'(c);
        apply(v, base + 1 + c);
      end
      v.t0  = 1'b0;
      v.cnt = CW'(0);
      apply(v, base + 6);
      v.t0  = 1'b1;
      v.cnt = CW'(1);
      apply(v, base + 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
